// File: rtl/id_fwd_stage_pkg.sv
// Shared definitions for the decode/forwarding stage.
//   DATA_W_DEF / REG_AW_DEF : default operand and register-number widths
//   ZERO_REG                : architectural register that always reads zero
//   PAYLOAD_*               : field layout of the opaque IF->ID bundle
package id_fwd_stage_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned REG_AW_DEF    = 5;
  localparam int unsigned NUM_FWD_DEF   = 3;
  localparam int unsigned PAYLOAD_W_DEF = 96;
  localparam int unsigned CNT_W_DEF     = 16;

  localparam int unsigned ZERO_REG      = 0;

  // Bundle layout: {inst, npc, pc}
  localparam int unsigned PAYLOAD_PC_LSB   = 0;
  localparam int unsigned PAYLOAD_NPC_LSB  = 32;
  localparam int unsigned PAYLOAD_INST_LSB = 64;
  localparam int unsigned PAYLOAD_FIELD_W  = 32;

endpackage

// File: rtl/id_fwd_stage_fwd_select.sv
// Per-source operand resolution.
//   used_in, num_in      : registered source-register descriptor
//   rf_data_in           : combinational regfile read data for this source
//   fwd_valid_in/wnum_in : producer stages holding a register writer (0 = youngest)
//   fwd_ready_in/data_in : producer result availability and value
//   op_out               : resolved operand
//   hazard_out           : youngest matching producer has no result yet
module fwd_select
  import id_fwd_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_AW  = REG_AW_DEF,
  parameter int unsigned NUM_FWD = NUM_FWD_DEF
) (
  input  logic                      used_in,
  input  logic [REG_AW-1:0]         num_in,
  input  logic [DATA_W-1:0]         rf_data_in,
  input  logic [NUM_FWD-1:0]        fwd_valid_in,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wnum_in,
  input  logic [NUM_FWD-1:0]        fwd_ready_in,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_in,
  output logic [DATA_W-1:0]         op_out,
  output logic                      hazard_out
);

  logic found;

  // First match in ascending index order is the youngest producer; once it is
  // found, older stages are ignored even if they hold a ready result.
  always_comb begin
    op_out     = rf_data_in;
    hazard_out = 1'b0;
    found      = 1'b0;
    if (num_in == REG_AW'(ZERO_REG)) begin
      op_out = '0;
    end else if (used_in) begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_valid_in[i] &&
            fwd_wnum_in[i*REG_AW +: REG_AW] == num_in) begin
          found = 1'b1;
          if (fwd_ready_in[i]) begin
            op_out = fwd_data_in[i*DATA_W +: DATA_W];
          end else begin
            hazard_out = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode pipeline slot between IF and EXE with operand forwarding.
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush_in              : kill held instruction, block capture
//   if_*                  : upstream handshake, bundle and decoded sources
//   id_allowin_out        : this stage accepts this cycle
//   exe_allowin_in        : downstream accepts
//   id_valid_out          : held instruction valid, operands ready, not flushed
//   id_payload_out        : held bundle
//   id_src*_num_out       : registered regfile read addresses
//   rf_rd*_in             : regfile read data for those addresses
//   fwd_*                 : producer stages, index 0 youngest (EXE)
//   id_op*_out            : resolved operands
//   id_stall_cnt_out      : saturating count of operand-hazard stall cycles
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned NUM_FWD   = NUM_FWD_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_in,
  input  logic                      if_valid_in,
  output logic                      id_allowin_out,
  input  logic [PAYLOAD_W-1:0]      if_payload_in,
  input  logic [REG_AW-1:0]         if_src1_num_in,
  input  logic [REG_AW-1:0]         if_src2_num_in,
  input  logic                      if_src1_used_in,
  input  logic                      if_src2_used_in,
  input  logic                      exe_allowin_in,
  output logic                      id_valid_out,
  output logic [PAYLOAD_W-1:0]      id_payload_out,
  output logic [REG_AW-1:0]         id_src1_num_out,
  output logic [REG_AW-1:0]         id_src2_num_out,
  input  logic [DATA_W-1:0]         rf_rd1_in,
  input  logic [DATA_W-1:0]         rf_rd2_in,
  input  logic [NUM_FWD-1:0]        fwd_valid_in,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wnum_in,
  input  logic [NUM_FWD-1:0]        fwd_ready_in,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data_in,
  output logic [DATA_W-1:0]         id_op1_out,
  output logic [DATA_W-1:0]         id_op2_out,
  output logic [CNT_W-1:0]          id_stall_cnt_out
);

  logic                 valid_r;
  logic [PAYLOAD_W-1:0] payload_r;
  logic [REG_AW-1:0]    src1_num_r;
  logic [REG_AW-1:0]    src2_num_r;
  logic                 src1_used_r;
  logic                 src2_used_r;
  logic [CNT_W-1:0]     stall_cnt_r;

  logic src1_hazard;
  logic src2_hazard;
  logic ready;
  logic allowin;

  fwd_select #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_src1 (
    .used_in      (src1_used_r),
    .num_in       (src1_num_r),
    .rf_data_in   (rf_rd1_in),
    .fwd_valid_in (fwd_valid_in),
    .fwd_wnum_in  (fwd_wnum_in),
    .fwd_ready_in (fwd_ready_in),
    .fwd_data_in  (fwd_data_in),
    .op_out       (id_op1_out),
    .hazard_out   (src1_hazard)
  );

  fwd_select #(
    .DATA_W  (DATA_W),
    .REG_AW  (REG_AW),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_src2 (
    .used_in      (src2_used_r),
    .num_in       (src2_num_r),
    .rf_data_in   (rf_rd2_in),
    .fwd_valid_in (fwd_valid_in),
    .fwd_wnum_in  (fwd_wnum_in),
    .fwd_ready_in (fwd_ready_in),
    .fwd_data_in  (fwd_data_in),
    .op_out       (id_op2_out),
    .hazard_out   (src2_hazard)
  );

  assign ready   = !(src1_hazard || src2_hazard);
  assign allowin = !valid_r || (ready && exe_allowin_in);

  assign id_allowin_out   = allowin;
  assign id_valid_out     = valid_r && ready && !flush_in;
  assign id_payload_out   = payload_r;
  assign id_src1_num_out  = src1_num_r;
  assign id_src2_num_out  = src2_num_r;
  assign id_stall_cnt_out = stall_cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      payload_r   <= '0;
      src1_num_r  <= '0;
      src2_num_r  <= '0;
      src1_used_r <= 1'b0;
      src2_used_r <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      // Only operand hazards count; a downstream back-pressure stall does not.
      if (valid_r && !ready && !flush_in && stall_cnt_r != '1) begin
        stall_cnt_r <= stall_cnt_r + 1'b1;
      end
      if (flush_in) begin
        valid_r <= 1'b0;
      end else if (allowin) begin
        valid_r <= if_valid_in;
        if (if_valid_in) begin
          payload_r   <= if_payload_in;
          src1_num_r  <= if_src1_num_in;
          src2_num_r  <= if_src2_num_in;
          src1_used_r <= if_src1_used_in;
          src2_used_r <= if_src2_used_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NF  = 3;
  localparam int unsigned PW  = 96;
  localparam int unsigned CW  = 4;   // narrow counter so saturation is reachable
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          flush_in;
  logic          if_valid_in;
  logic          id_allowin_out;
  logic [PW-1:0] if_payload_in;
  logic [AW-1:0] if_src1_num_in, if_src2_num_in;
  logic          if_src1_used_in, if_src2_used_in;
  logic          exe_allowin_in;
  logic          id_valid_out;
  logic [PW-1:0] id_payload_out;
  logic [AW-1:0] id_src1_num_out, id_src2_num_out;
  logic [DW-1:0] rf_rd1_in, rf_rd2_in;
  logic [NF-1:0] fwd_valid_in;
  logic [NF*AW-1:0] fwd_wnum_in;
  logic [NF-1:0] fwd_ready_in;
  logic [NF*DW-1:0] fwd_data_in;
  logic [DW-1:0] id_op1_out, id_op2_out;
  logic [CW-1:0] id_stall_cnt_out;

  id_fwd_stage #(
    .DATA_W    (DW),
    .REG_AW    (AW),
    .NUM_FWD   (NF),
    .PAYLOAD_W (PW),
    .CNT_W     (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_in         (flush_in),
    .if_valid_in      (if_valid_in),
    .id_allowin_out   (id_allowin_out),
    .if_payload_in    (if_payload_in),
    .if_src1_num_in   (if_src1_num_in),
    .if_src2_num_in   (if_src2_num_in),
    .if_src1_used_in  (if_src1_used_in),
    .if_src2_used_in  (if_src2_used_in),
    .exe_allowin_in   (exe_allowin_in),
    .id_valid_out     (id_valid_out),
    .id_payload_out   (id_payload_out),
    .id_src1_num_out  (id_src1_num_out),
    .id_src2_num_out  (id_src2_num_out),
    .rf_rd1_in        (rf_rd1_in),
    .rf_rd2_in        (rf_rd2_in),
    .fwd_valid_in     (fwd_valid_in),
    .fwd_wnum_in      (fwd_wnum_in),
    .fwd_ready_in     (fwd_ready_in),
    .fwd_data_in      (fwd_data_in),
    .id_op1_out       (id_op1_out),
    .id_op2_out       (id_op2_out),
    .id_stall_cnt_out (id_stall_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid;
  logic [PW-1:0] m_payload;
  logic [AW-1:0] m_n1, m_n2;
  logic          m_u1, m_u2;
  int            m_cnt;

  typedef struct packed {
    logic          hz1;
    logic          hz2;
    logic          allowin;
    logic          vout;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } exp_t;

  // Returns {hazard, operand}: youngest producer writing num decides the value.
  function automatic logic [DW:0] resolve(input logic used, input logic [AW-1:0] num,
                                          input logic [DW-1:0] rf);
    int sel;
    sel = -1;
    if (num == 0) return {1'b0, {DW{1'b0}}};
    if (!used) return {1'b0, rf};
    for (int i = NF - 1; i >= 0; i--)
      if (fwd_valid_in[i] && fwd_wnum_in[i*AW +: AW] == num) sel = i;
    if (sel < 0) return {1'b0, rf};
    if (fwd_ready_in[sel]) return {1'b0, fwd_data_in[sel*DW +: DW]};
    return {1'b1, rf};
  endfunction

  function automatic exp_t eval_model();
    exp_t e;
    logic [DW:0] r1, r2;
    logic rdy;
    r1 = resolve(m_u1, m_n1, rf_rd1_in);
    r2 = resolve(m_u2, m_n2, rf_rd2_in);
    rdy = !(r1[DW] || r2[DW]);
    e.hz1 = r1[DW];
    e.hz2 = r2[DW];
    e.op1 = r1[DW-1:0];
    e.op2 = r2[DW-1:0];
    e.allowin = !m_valid || (rdy && exe_allowin_in);
    e.vout = m_valid && rdy && !flush_in;
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_payload = '0; m_n1 = '0; m_n2 = '0;
    m_u1 = 1'b0; m_u2 = 1'b0; m_cnt = 0;
  endtask

  task automatic model_update();
    exp_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e = eval_model();
    if (m_valid && (e.hz1 || e.hz2) && !flush_in && m_cnt < CNT_MAX) m_cnt++;
    if (flush_in) m_valid = 1'b0;
    else if (e.allowin && if_valid_in) begin
      m_valid = 1'b1; m_payload = if_payload_in;
      m_n1 = if_src1_num_in; m_n2 = if_src2_num_in;
      m_u1 = if_src1_used_in; m_u2 = if_src2_used_in;
    end else if (e.allowin) m_valid = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_valid", 128'(id_valid_out), 128'(1'b0));
      chk("rst_allowin", 128'(id_allowin_out), 128'(1'b1));
      chk("rst_cnt", 128'(id_stall_cnt_out), 128'(0));
    end else begin
      e = eval_model();
      chk("valid", 128'(id_valid_out), 128'(e.vout));
      chk("allowin", 128'(id_allowin_out), 128'(e.allowin));
      chk("cnt", 128'(id_stall_cnt_out), 128'(m_cnt));
      chk("payload", 128'(id_payload_out), 128'(m_payload));
      chk("src1_num", 128'(id_src1_num_out), 128'(m_n1));
      chk("src2_num", 128'(id_src2_num_out), 128'(m_n2));
      if (e.vout) begin
        chk("op1", 128'(id_op1_out), 128'(e.op1));
        chk("op2", 128'(id_op2_out), 128'(e.op2));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    flush_in = 1'b0; if_valid_in = 1'b0; exe_allowin_in = 1'b1;
    if_payload_in = '0; if_src1_num_in = '0; if_src2_num_in = '0;
    if_src1_used_in = 1'b0; if_src2_used_in = 1'b0;
    rf_rd1_in = '0; rf_rd2_in = '0;
    fwd_valid_in = '0; fwd_wnum_in = '0; fwd_ready_in = '0; fwd_data_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] n1, input logic u1,
                       input logic [AW-1:0] n2, input logic u2);
    if_valid_in = 1'b1;
    if_payload_in = {$urandom, $urandom, $urandom};
    if_src1_num_in = n1; if_src1_used_in = u1;
    if_src2_num_in = n2; if_src2_used_in = u2;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("init_valid", 128'(id_valid_out), 128'(1'b0));
    chk("init_allowin", 128'(id_allowin_out), 128'(1'b1));
    chk("init_cnt", 128'(id_stall_cnt_out), 128'(0));
    #9 rst_n = 1'b1;

    // no hazard: operands from the regfile
    step();
    offer(5'd3, 1'b1, 5'd4, 1'b1);
    exe_allowin_in = 1'b0;
    rf_rd1_in = 32'h11; rf_rd2_in = 32'h22;
    step();
    if_valid_in = 1'b0;
    #1;
    chk("nohz_valid", 128'(id_valid_out), 128'(1'b1));
    chk("nohz_op1", 128'(id_op1_out), 128'(32'h11));
    chk("nohz_op2", 128'(id_op2_out), 128'(32'h22));

    // EXE forward wins over an older ready WB result (back-to-back capture)
    idle();
    exe_allowin_in = 1'b1;
    offer(5'd7, 1'b1, 5'd0, 1'b0);
    step();
    idle();
    exe_allowin_in = 1'b0;
    fwd_valid_in = 3'b101; fwd_ready_in = 3'b101;
    fwd_wnum_in = {5'd7, 5'd0, 5'd7};
    fwd_data_in = {32'hBBBB, 32'h0, 32'hAAAA};
    #1;
    chk("exe_fwd_op1", 128'(id_op1_out), 128'(32'hAAAA));
    chk("exe_fwd_valid", 128'(id_valid_out), 128'(1'b1));

    // register 0 reads zero and never stalls
    idle();
    offer(5'd0, 1'b1, 5'd5, 1'b0);
    step();
    idle();
    exe_allowin_in = 1'b0;
    fwd_valid_in = 3'b001; fwd_wnum_in = '0; fwd_ready_in = '0;
    rf_rd1_in = 32'hDEAD; rf_rd2_in = 32'h1234;
    #1;
    chk("r0_op1", 128'(id_op1_out), 128'(32'h0));
    chk("r0_op2_unused", 128'(id_op2_out), 128'(32'h1234));
    chk("r0_valid", 128'(id_valid_out), 128'(1'b1));

    // load-use stall resolved once the producer reaches stage 1
    idle();
    offer(5'd0, 1'b0, 5'd9, 1'b1);
    rf_rd2_in = 32'h77;
    step();
    if_valid_in = 1'b0;
    fwd_valid_in = 3'b001; fwd_wnum_in = {5'd0, 5'd0, 5'd9}; fwd_ready_in = '0;
    #1;
    chk("lu_valid0", 128'(id_valid_out), 128'(1'b0));
    chk("lu_allowin0", 128'(id_allowin_out), 128'(1'b0));
    step();
    #1;
    chk("lu_valid1", 128'(id_valid_out), 128'(1'b0));
    chk("lu_allowin1", 128'(id_allowin_out), 128'(1'b0));
    step();
    fwd_valid_in = 3'b010; fwd_wnum_in = {5'd0, 5'd9, 5'd0}; fwd_ready_in = 3'b010;
    fwd_data_in = {32'h0, 32'h55, 32'h0};
    exe_allowin_in = 1'b0;
    #1;
    chk("lu_cnt", 128'(id_stall_cnt_out), 128'(2));
    chk("lu_op2", 128'(id_op2_out), 128'(32'h55));
    chk("lu_valid", 128'(id_valid_out), 128'(1'b1));

    // async reset mid-stall with counter at 5
    step();
    fwd_valid_in = 3'b001; fwd_wnum_in = {5'd0, 5'd0, 5'd9}; fwd_ready_in = '0;
    step(); step(); step();
    #1;
    chk("pre_rst_cnt", 128'(id_stall_cnt_out), 128'(5));
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 128'(id_valid_out), 128'(1'b0));
    chk("arst_allowin", 128'(id_allowin_out), 128'(1'b1));
    chk("arst_cnt", 128'(id_stall_cnt_out), 128'(0));
    step();
    rst_n = 1'b1;
    idle();

    // flush during a stall
    offer(5'd12, 1'b1, 5'd0, 1'b0);
    exe_allowin_in = 1'b0;
    step();
    if_valid_in = 1'b0;
    fwd_valid_in = 3'b001; fwd_wnum_in = {5'd0, 5'd0, 5'd12}; fwd_ready_in = '0;
    step();
    flush_in = 1'b1;
    #1;
    chk("fl_valid", 128'(id_valid_out), 128'(1'b0));
    chk("fl_cnt_before", 128'(id_stall_cnt_out), 128'(1));
    step();
    flush_in = 1'b0; fwd_valid_in = '0;
    #1;
    chk("fl_valid_after", 128'(id_valid_out), 128'(1'b0));
    chk("fl_allowin_after", 128'(id_allowin_out), 128'(1'b1));
    chk("fl_cnt_after", 128'(id_stall_cnt_out), 128'(1));

    // flush masks an otherwise ready instruction in the same cycle
    offer(5'd2, 1'b1, 5'd3, 1'b1);
    step();
    if_valid_in = 1'b0; flush_in = 1'b1;
    #1;
    chk("fl2_valid", 128'(id_valid_out), 128'(1'b0));
    step();
    flush_in = 1'b0;
    #1;
    chk("fl2_valid_after", 128'(id_valid_out), 128'(1'b0));

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if_valid_in     = ($urandom_range(0, 3) != 0);
      if_payload_in   = {$urandom, $urandom, $urandom};
      if_src1_num_in  = AW'($urandom_range(0, 7));
      if_src2_num_in  = AW'($urandom_range(0, 7));
      if_src1_used_in = ($urandom_range(0, 3) != 0);
      if_src2_used_in = ($urandom_range(0, 3) != 0);
      exe_allowin_in  = ($urandom_range(0, 3) != 0);
      flush_in        = ($urandom_range(0, 15) == 0);
      rf_rd1_in       = $urandom;
      rf_rd2_in       = $urandom;
      fwd_valid_in    = NF'($urandom);
      fwd_ready_in    = NF'($urandom);
      for (int i = 0; i < NF; i++) begin
        fwd_wnum_in[i*AW +: AW] = AW'($urandom_range(0, 7));
        fwd_data_in[i*DW +: DW] = $urandom;
      end
    end

    step();
    idle();
    #10;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
